// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction store for the CPU fetch port.
// After reset the store is filled from a valid/ready load stream (LOAD state).
// It then serves zero-latency fetches until the next reset (RUN state).
// Optional feature macro: RELOAD_EN. When it is defined, the reload_i input is
// present and lets RUN fall back to LOAD for a fresh image.
// dbg_state mirrors the FSM state for observation: 0 = LOAD, 1 = RUN.

module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // Load stream handshake: a beat transfers on a rising edge where
  // ld_valid_i & ld_ready_o are both 1. The source must hold ld_data_i and
  // ld_last_i stable while ld_valid_i is high. ld_ready_o is 1 exactly while
  // loading. ld_last_i has meaning only on a transferred beat.
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [DATA_W-1:0]     ld_data_i,
  input  logic                  ld_last_i,
  output logic [DEPTH_LOG2:0]   ld_count_o,
  output logic                  boot_done_o,
`ifdef RELOAD_EN
  input  logic                  reload_i,
`endif
  input  logic                  rom_ce_i,
  input  logic [ADDR_W-1:0]     rom_addr_i,
  output logic [DATA_W-1:0]     rom_data_o,
  output logic                  rom_err_o,
  output logic                  dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   wptr;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic                    accept;
  logic                    store_full;
  logic                    wr_en;
  logic                    run;
  logic                    addr_bad;
  logic [DEPTH_LOG2-1:0]   rd_idx;

  // Handshake and write qualification.
  always_comb begin
    accept     = ld_valid_i & ld_ready_o;
    store_full = &wptr;
    // Writes are suppressed while reset is held: the FSM sits in LOAD then,
    // and a stray valid beat must not disturb the retained image.
    wr_en      = accept & ~rst;
    run        = (state == S_RUN);
    dbg_state  = run;
  end

  // Load/run control; all outputs other than the fetch path are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_LOAD;
      wptr        <= '0;
      ld_count_o  <= '0;
      ld_ready_o  <= 1'b1;
      boot_done_o <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            // At the last slot wptr wraps to 0. This is harmless: the FSM
            // leaves LOAD on that same edge, so nothing is written after it.
            wptr       <= wptr + 1'b1;
            ld_count_o <= ld_count_o + 1'b1;
            if (ld_last_i || store_full) begin
              state       <= S_RUN;
              ld_ready_o  <= 1'b0;
              boot_done_o <= 1'b1;
            end
          end
        end
        S_RUN: begin
`ifdef RELOAD_EN
          if (reload_i) begin
            state       <= S_LOAD;
            wptr        <= '0;
            ld_count_o  <= '0;
            ld_ready_o  <= 1'b1;
            boot_done_o <= 1'b0;
          end
`endif
        end
        default: begin
          state       <= S_LOAD;
          wptr        <= '0;
          ld_count_o  <= '0;
          ld_ready_o  <= 1'b1;
          boot_done_o <= 1'b0;
        end
      endcase
    end
  end

  // Store write port. The array has no reset so that an image survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= ld_data_i;
    end
  end

  // Zero-latency fetch. Any fetch that cannot be served returns 0, which the
  // CPU executes as a NOP: during LOAD, with ce low, or on a bad address.
  always_comb begin
    rd_idx     = rom_addr_i[DEPTH_LOG2+1:2];
    addr_bad   = (rom_addr_i[1:0] != 2'b00) ||
                 (rom_addr_i[ADDR_W-1:DEPTH_LOG2+2] != '0);
    rom_err_o  = run & rom_ce_i & addr_bad;
    rom_data_o = '0;
    if (run && rom_ce_i && !addr_bad) begin
      rom_data_o = mem[rd_idx];
    end
  end

endmodule
